// File: rtl/pcihellocore_switches_inport.sv
// Avalon-MM input port for board switches/keys: synchronise, debounce, capture edges,
// and raise a level interrupt for unmasked captured edges.
module pcihellocore_switches_inport #(
    parameter int               WIDTH         = 32,
    parameter int               DEBOUNCE_TICK = 50000,
    parameter int               EDGE_TYPE     = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int            CW        = $clog2(DEBOUNCE_TICK);
    localparam logic [CW-1:0] TICK_LAST = CW'(DEBOUNCE_TICK - 1);

    logic [CW-1:0]    count;
    logic             tick;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] samp;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clear_bits;
    logic             wr_en;

    assign tick  = (count == TICK_LAST);
    assign wr_en = chipselect && !write_n;

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= RESET_VALUE;
            sync2 <= RESET_VALUE;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // A bit of deb only follows sync2 once two consecutive tick samples agree.
    always_ff @(posedge clk) begin
        if (reset) begin
            samp  <= RESET_VALUE;
            deb   <= RESET_VALUE;
            deb_d <= RESET_VALUE;
        end else begin
            deb_d <= deb;
            if (tick) begin
                samp <= sync2;
                deb  <= (deb & (sync2 ^ samp)) | (sync2 & ~(sync2 ^ samp));
            end
        end
    end

    always_comb begin
        edge_det = deb & ~deb_d;
        case (EDGE_TYPE)
            1:       edge_det = ~deb & deb_d;
            2:       edge_det = deb ^ deb_d;
            default: edge_det = deb & ~deb_d;
        endcase
    end

    assign clear_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // A new edge takes priority over a same-cycle host clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            if (wr_en && address == 2'd2) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            edgecapture <= (edgecapture & ~clear_bits) | edge_det;
        end
    end

    always_comb begin
        readdata = 32'h0;
        case (address)
            2'd0:    readdata = 32'(deb);
            2'd2:    readdata = 32'(irqmask);
            2'd3:    readdata = 32'(edgecapture);
            default: readdata = 32'h0;
        endcase
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_pcihellocore_switches_inport.sv
// Bench for pcihellocore_switches_inport: rising-edge and any-edge instances driven in
// parallel and compared every cycle against a tick-sample reference model.
module tb_pcihellocore_switches_inport;

    localparam int WIDTH = 4;
    localparam int DT    = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic [31:0]      readdata_r;
    logic [31:0]      readdata_a;
    logic             irq_r;
    logic             irq_a;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int         m_cyc;
    logic [3:0] m_q[$];
    logic [3:0] m_samp;
    logic [3:0] m_deb;
    logic [3:0] m_deb_old;
    logic [3:0] m_mask;
    logic [3:0] m_ec_r;
    logic [3:0] m_ec_a;

    always #5 clk = ~clk;

    pcihellocore_switches_inport #(
        .WIDTH(WIDTH), .DEBOUNCE_TICK(DT), .EDGE_TYPE(0), .RESET_VALUE(4'h0)
    ) dut_r (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_r),
        .in_port(in_port), .irq(irq_r)
    );

    pcihellocore_switches_inport #(
        .WIDTH(WIDTH), .DEBOUNCE_TICK(DT), .EDGE_TYPE(2), .RESET_VALUE(4'h0)
    ) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_a),
        .in_port(in_port), .irq(irq_a)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a, input logic [3:0] ec);
        case (a)
            2'd0:    return {28'h0, m_deb};
            2'd2:    return {28'h0, m_mask};
            2'd3:    return {28'h0, ec};
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge: the debounced value follows the input seen two
    // edges earlier, once two tick samples (every DT-th edge after reset) agree.
    task automatic model_step();
        logic       wr;
        logic [3:0] clr;
        logic [3:0] s;
        logic [3:0] agree;
        logic [3:0] deb_next;
        if (reset) begin
            m_cyc = 0;
            m_q = '{4'h0, 4'h0};
            m_samp = 4'h0; m_deb = 4'h0; m_deb_old = 4'h0;
            m_mask = 4'h0; m_ec_r = 4'h0; m_ec_a = 4'h0;
        end else begin
            m_cyc++;
            wr  = chipselect && !write_n;
            clr = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
            m_ec_r = (m_ec_r & ~clr) | (m_deb & ~m_deb_old);
            m_ec_a = (m_ec_a & ~clr) | (m_deb ^ m_deb_old);
            if (wr && address == 2'd2) m_mask = writedata[3:0];
            deb_next = m_deb;
            if (m_cyc % DT == 0) begin
                s = m_q[0];
                agree = ~(s ^ m_samp);
                deb_next = (m_deb & ~agree) | (s & agree);
                m_samp = s;
            end
            m_deb_old = m_deb;
            m_deb = deb_next;
            m_q.push_back(in_port);
            void'(m_q.pop_front());
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] in_v, input logic cs,
                                 input logic wn, input logic [1:0] addr, input logic [31:0] wd);
        reset = rst; in_port = in_v; chipselect = cs; write_n = wn;
        address = addr; writedata = wd;
        @(posedge clk);
        model_step();
        @(negedge clk);
        checkOutput("rd_rise", readdata_r, model_read(address, m_ec_r));
        checkOutput("rd_any", readdata_a, model_read(address, m_ec_a));
        checkOutput("irq_rise", {31'h0, irq_r}, {31'h0, |(m_ec_r & m_mask)});
        checkOutput("irq_any", {31'h0, irq_a}, {31'h0, |(m_ec_a & m_mask)});
    endtask

    task automatic idle(input int n, input logic [3:0] in_v);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, in_v, 1'b0, 1'b1, 2'd0, 32'h0);
    endtask

    task automatic host_read(input logic [1:0] a, input logic [3:0] in_v);
        applyStimulus(1'b0, in_v, 1'b1, 1'b1, a, 32'h0);
    endtask

    task automatic host_write(input logic [1:0] a, input logic [31:0] wd, input logic [3:0] in_v);
        applyStimulus(1'b0, in_v, 1'b1, 1'b0, a, wd);
    endtask

    initial begin
        logic reached;
        logic found;
        logic [3:0] hold_v;
        int hold_len;

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 32'h0);

        host_read(2'd0, 4'h0);
        checkOutput("reset_data", readdata_r, 32'h0);
        host_read(2'd2, 4'h0);
        checkOutput("reset_mask", readdata_r, 32'h0);
        host_read(2'd3, 4'h0);
        checkOutput("reset_ec", readdata_r, 32'h0);
        checkOutput("reset_irq", {31'h0, irq_r}, 32'h0);

        reached = 1'b0;
        for (int i = 0; i < 19 && !reached; i++) begin
            host_read(2'd0, 4'h5);
            if (readdata_r == 32'h5) reached = 1'b1;
        end
        checkOutput("deb_latency", {31'h0, reached}, 32'h1);
        idle(3, 4'h5);
        host_read(2'd3, 4'h5);
        checkOutput("ec_after_rise", readdata_r, 32'h5);
        checkOutput("irq_masked", {31'h0, irq_r}, 32'h0);

        host_write(2'd2, 32'h1, 4'h5);
        checkOutput("irq_unmasked", {31'h0, irq_r}, 32'h1);
        host_write(2'd3, 32'h1, 4'h5);
        host_read(2'd3, 4'h5);
        checkOutput("ec_w1c", readdata_r, 32'h4);
        checkOutput("irq_cleared", {31'h0, irq_r}, 32'h0);

        while (m_cyc % DT != 3) idle(1, 4'h5);
        idle(3, 4'h7);
        idle(20, 4'h5);
        host_read(2'd0, 4'h5);
        checkOutput("glitch_data", readdata_r, 32'h5);
        host_read(2'd3, 4'h5);
        checkOutput("glitch_ec", readdata_r, 32'h4);

        idle(20, 4'h1);
        host_write(2'd3, 32'hF, 4'h1);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            idle(1, 4'h5);
            if (m_deb[2] && !m_deb_old[2]) found = 1'b1;
        end
        checkOutput("rise_window", {31'h0, found}, 32'h1);
        host_write(2'd3, 32'h4, 4'h5);
        host_read(2'd3, 4'h5);
        checkOutput("set_wins", {31'h0, readdata_r[2]}, 32'h1);

        host_write(2'd3, 32'hF, 4'h5);
        idle(20, 4'h4);
        host_read(2'd3, 4'h4);
        checkOutput("any_edge_fall", {31'h0, readdata_a[0]}, 32'h1);
        checkOutput("rise_ignores_fall", {31'h0, readdata_r[0]}, 32'h0);

        idle(12, 4'h0);
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 2'd2, 32'hF);
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 32'h0);
        idle(30, 4'h0);
        host_read(2'd0, 4'h0);
        checkOutput("rst_mid_data", readdata_r, 32'h0);
        host_read(2'd2, 4'h0);
        checkOutput("rst_mid_mask", readdata_a, 32'h0);
        host_read(2'd3, 4'h0);
        checkOutput("rst_mid_ec", readdata_a, 32'h0);

        for (int seg = 0; seg < 250; seg++) begin
            hold_v   = 4'($urandom);
            hold_len = $urandom_range(1, 24);
            for (int c = 0; c < hold_len; c++) begin
                applyStimulus(($urandom % 500) == 0, hold_v, ($urandom % 3) == 0,
                              1'($urandom), 2'($urandom), $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
